mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit directly upstream of the byte-addressed, big-endian word RAM.
- Accepts byte/half/word load and store requests from the CPU execute stage over a valid/ready handshake and sequences them into RAM commands.
- Stores narrower than a word use read-modify-write.
- Loads are extracted and sign- or zero-extended; misaligned or out-of-range accesses are reported as faults.

Parameters:
- MEM_SIZE, 4096, RAM size in bytes; must be a multiple of 4.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and faults
- i_signed  in  1  loads: sign-extend when 1
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- o_rvalid  out  1  response valid
- i_rready  in  1  response accepted
- o_rdata  out  32  load result, extended; 0 for stores and faults
- o_fault  out  1  access faulted; no RAM write occurred
- o_ram_do  out  2  command to RAM: `RAM_NOP / `RAM_READ / `RAM_WRITE
- o_ram_addr  out  32  word-aligned RAM address
- o_ram_val  out  32  RAM write data
- i_ram_val  in  32  RAM read data, combinational from o_ram_addr

Behaviour:
- Reset, async, all outputs:
  - state = IDLE, o_ready = 1, o_rvalid = 0, o_rdata = 0, o_fault = 0.
  - o_ram_do = `RAM_NOP, o_ram_addr = 0, o_ram_val = 0.
- Reset mid-operation: state returns to IDLE and the request is dropped. A write is issued only in WRITE, so an interrupted RMW leaves memory untouched unless the WRITE edge already occurred.
- Byte order is big-endian: byte offset 0 maps to word bits [31:24]; offset 3 maps to [7:0]. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- IDLE:
  - o_ready = 1, o_ram_do = `RAM_NOP.
  - Accept on i_valid & o_ready: latch we, size, signed, addr, wdata.
  - Fault check at accept time, any of:
    - size == 3
    - half with addr[0] = 1
    - word with addr[1:0] != 0
    - (addr & ~3) > MEM_SIZE-4
  - Faulting request → RESP with fault = 1.
  - Load, or sub-word store → READ.
  - Word store → WRITE.
- READ:
  - o_ram_do = `RAM_READ, o_ram_addr = addr & ~3.
  - Capture i_ram_val into rbuf at the clock edge.
  - Load → RESP; o_rdata = lane extracted from the captured word and extended.
  - Store → WRITE.
- WRITE:
  - o_ram_do = `RAM_WRITE, o_ram_addr = addr & ~3.
  - o_ram_val = wdata for a word store; otherwise rbuf with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - Next state → RESP.
- RESP:
  - o_rvalid = 1; o_ready = 0; o_ram_do = `RAM_NOP.
  - o_rdata and o_fault held stable until i_rready; on i_rready → IDLE.
  - No new request is accepted in the RESP cycle, so there is no simultaneous accept and response.
- o_ready = 0 in every state except IDLE.
- Latency from the accept edge to o_rvalid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - fault: 1 cycle
- RAM commands are registered outputs; o_ram_addr and o_ram_do change only on clock edges.
- Address wrap: none. Any address ≥ MEM_SIZE faults, including 0xFFFFFFFC.

Test Plan:
- Word store 0xDEADBEEF @0x10 then word load @0x10 → RAM bytes 0x10..0x13 = DE,AD,BE,EF; o_rdata = 0xDEADBEEF, o_fault = 0; each o_rvalid 2 cycles after accept.
- Byte store 0x7F @0x12 over word 0xDEADBEEF → one RAM READ, then WRITE 0xDEAD7FEF; o_rvalid 3 cycles after accept.
- Loads from word 0xDEAD80EF @0x10:
  - signed byte @0x12 → 0xFFFFFF80
  - unsigned byte @0x12 → 0x00000080
  - signed half @0x10 → 0xFFFFDEAD
- Misaligned/out-of-range requests (half @0x11, word @0x12, word @MEM_SIZE, size = 3) → o_fault = 1 one cycle after accept, o_rdata = 0, no `RAM_WRITE issued, memory unchanged.
- Backpressure: hold i_rready = 0 for 5 cycles in RESP → o_rvalid and o_rdata stable, o_ready = 0, a new i_valid is not accepted; it is accepted the cycle after i_rready.
- Assert i_rst during the WRITE-pending RMW (state READ) → outputs reach reset values immediately; memory word unchanged; next request completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit in front of a big-endian, byte-addressed word RAM.
// Sequences byte/half/word requests into RAM read/write commands, with RMW for sub-word stores.

`ifndef RAM_NOP
`define RAM_NOP 2'd0
`endif
`ifndef RAM_READ
`define RAM_READ 2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif

module mem_lsu #(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [1:0]  o_ram_do,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_val,
  input  logic [31:0] i_ram_val
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] rbuf_q;
  logic [1:0]  ram_do_q, ram_do_d;
  logic [31:0] ram_addr_q, ram_addr_d;

  logic        accept;
  logic        req_fault;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state_q == StIdle) && i_valid;

  // Word-aligned address past the last full word is out of range; no wrap-around.
  always_comb begin
    req_fault = (i_size == 2'd3)
              | ((i_size == 2'd1) & i_addr[0])
              | ((i_size == 2'd2) & (i_addr[1:0] != 2'b00))
              | ({i_addr[31:2], 2'b00} > (MEM_SIZE - 32'd4));
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    lane_sh   = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    if (size_q == 2'd0) begin
      lane_sh   = {~off_q, 3'b000};
      lane_mask = 32'h0000_00FF;
    end else if (size_q == 2'd1) begin
      lane_sh   = {~off_q[1], 4'b0000};
      lane_mask = 32'h0000_FFFF;
    end
  end

  always_comb begin
    lane     = (rbuf_q >> lane_sh) & lane_mask;
    load_val = lane;
    if (signed_q) begin
      if (size_q == 2'd0) begin
        load_val = {{24{lane[7]}}, lane[7:0]};
      end else if (size_q == 2'd1) begin
        load_val = {{16{lane[15]}}, lane[15:0]};
      end
    end
    merged = (rbuf_q & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
  end

  always_comb begin
    state_d    = state_q;
    ram_do_d   = `RAM_NOP;
    ram_addr_d = ram_addr_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          if (req_fault) begin
            state_d = StResp;
          end else begin
            ram_addr_d = {i_addr[31:2], 2'b00};
            if (i_we && (i_size == 2'd2)) begin
              state_d  = StWrite;
              ram_do_d = `RAM_WRITE;
            end else begin
              state_d  = StRead;
              ram_do_d = `RAM_READ;
            end
          end
        end
      end
      StRead: begin
        if (we_q) begin
          state_d  = StWrite;
          ram_do_d = `RAM_WRITE;
        end else begin
          state_d = StResp;
        end
      end
      StWrite: state_d = StResp;
      StResp: begin
        if (i_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      off_q      <= 2'd0;
      wdata_q    <= 32'd0;
      fault_q    <= 1'b0;
      rbuf_q     <= 32'd0;
      ram_do_q   <= `RAM_NOP;
      ram_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      ram_do_q   <= ram_do_d;
      ram_addr_q <= ram_addr_d;
      if (accept) begin
        we_q     <= i_we;
        size_q   <= i_size;
        signed_q <= i_signed;
        off_q    <= i_addr[1:0];
        wdata_q  <= i_wdata;
        fault_q  <= req_fault;
      end
      if (state_q == StRead) begin
        rbuf_q <= i_ram_val;
      end
    end
  end

  always_comb begin
    o_ready    = (state_q == StIdle);
    o_rvalid   = (state_q == StResp);
    o_fault    = (state_q == StResp) && fault_q;
    o_rdata    = ((state_q == StResp) && !we_q && !fault_q) ? load_val : 32'd0;
    o_ram_do   = ram_do_q;
    o_ram_addr = ram_addr_q;
    o_ram_val  = 32'd0;
    if (state_q == StWrite) begin
      o_ram_val = (size_q == 2'd2) ? wdata_q : merged;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-array RAM, byte-level reference memory, directed steps then random traffic.

`ifndef RAM_NOP
`define RAM_NOP 2'd0
`endif
`ifndef RAM_READ
`define RAM_READ 2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif

module tb_mem_lsu;
  localparam int unsigned MEM = 4096;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_signed;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_rvalid;
  logic        i_rready;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [1:0]  o_ram_do;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_val;
  logic [31:0] i_ram_val;

  bit [7:0] ram     [MEM];
  bit [7:0] ref_mem [MEM];
  int n_rd = 0;
  int n_wr = 0;
  int errors = 0;
  int checks = 0;

  mem_lsu #(.MEM_SIZE(MEM)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_we      (i_we),
    .i_size    (i_size),
    .i_signed  (i_signed),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready),
    .o_rdata   (o_rdata),
    .o_fault   (o_fault),
    .o_ram_do  (o_ram_do),
    .o_ram_addr(o_ram_addr),
    .o_ram_val (o_ram_val),
    .i_ram_val (i_ram_val)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_ram_val = 32'd0;
    if (o_ram_addr <= MEM - 4) begin
      i_ram_val = {ram[o_ram_addr], ram[o_ram_addr + 32'd1],
                   ram[o_ram_addr + 32'd2], ram[o_ram_addr + 32'd3]};
    end
  end

  always @(posedge i_clk) begin
    if (o_ram_do == `RAM_READ) n_rd <= n_rd + 1;
    if (o_ram_do == `RAM_WRITE) begin
      n_wr <= n_wr + 1;
      if (o_ram_addr <= MEM - 4) begin
        for (int k = 0; k < 4; k++) ram[o_ram_addr + 32'(k)] <= o_ram_val[31 - 8 * k -: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= MEM);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit sgn,
                                             input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = {v[23:0], ref_mem[addr + 32'(i)]};
    if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a, input bit from_ref);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[31 - 8 * i -: 8] = from_ref ? ref_mem[a + 32'(i)] : ram[a + 32'(i)];
    end
    return w;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_rvalid"}, 32'(o_rvalid), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_fault"}, 32'(o_fault), 32'd0);
    chk({tag, "_ram_do"}, 32'(o_ram_do), 32'(`RAM_NOP));
    chk({tag, "_ram_addr"}, o_ram_addr, 32'd0);
    chk({tag, "_ram_val"}, o_ram_val, 32'd0);
  endtask

  // One request end to end; hold = cycles of response backpressure.
  task automatic run_req(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] got);
    int lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_data;
    bit flt;
    flt      = model_fault(size, addr);
    exp_data = (!flt && !we) ? model_load(size, sgn, addr) : 32'd0;
    if (flt) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end else if (size == 2'd2) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
    end
    @(negedge i_clk);
    chk("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_we = we; i_size = size; i_signed = sgn; i_addr = addr; i_wdata = wdata;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_valid = 1'b0;
    while (!o_rvalid && lat < 8) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    got = o_rdata;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", o_rdata, exp_data);
    chk("fault", 32'(o_fault), 32'(flt));
    chk("ram_reads", 32'(n_rd - rd0), 32'(exp_rd));
    chk("ram_writes", 32'(n_wr - wr0), 32'(exp_wr));
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1; i_we = 1'b0; i_size = 2'd2; i_addr = 32'h10;
      @(posedge i_clk);
      @(negedge i_clk);
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_rvalid", 32'(o_rvalid), 32'd1);
      chk("bp_rdata", o_rdata, exp_data);
    end
    i_rready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rready = 1'b0;
    chk("rvalid_drop", 32'(o_rvalid), 32'd0);
    if (hold > 0) begin
      chk("ready_after_bp", 32'(o_ready), 32'd1);
      i_valid = 1'b0;
    end
    if (we && !flt) begin
      for (int i = 0; i < (1 << size); i++) begin
        ref_mem[addr + 32'(i)] = wdata[8 * ((1 << size) - 1 - i) +: 8];
      end
    end
    if (!flt) chk("ram_word", word_at({addr[31:2], 2'b00}, 1'b0), word_at({addr[31:2], 2'b00}, 1'b1));
  endtask

  initial begin
    logic [31:0] got;
    int mism;
    logic [31:0] ra;
    int sel;
    i_rst = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_size = 2'd0; i_signed = 1'b0;
    i_addr = 32'd0; i_wdata = 32'd0; i_rready = 1'b0;
    repeat (2) @(negedge i_clk);
    check_reset("reset");
    i_rst = 1'b0;

    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
    chk("store_word_bytes", word_at(32'h10, 1'b0), 32'hDEADBEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got);
    chk("load_word", got, 32'hDEADBEEF);
    run_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000007F, 0, got);
    chk("store_byte_rmw", word_at(32'h10, 1'b0), 32'hDEAD7FEF);

    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD80EF, 0, got);
    run_req(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, 0, got);
    chk("load_sbyte", got, 32'hFFFFFF80);
    run_req(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, 0, got);
    chk("load_ubyte", got, 32'h00000080);
    run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 0, got);
    chk("load_shalf", got, 32'hFFFFDEAD);

    run_req(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, 0, got);
    chk("fault_half_rdata", got, 32'd0);
    run_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 0, got);
    run_req(1'b0, 2'd2, 1'b0, MEM, 32'd0, 0, got);
    run_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hCAFEF00D, 0, got);
    run_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h11111111, 0, got);
    chk("fault_mem_intact", word_at(32'h10, 1'b0), 32'hDEAD80EF);

    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, got);
    chk("bp_load", got, 32'hDEAD80EF);

    // Reset while a sub-word store is in its read phase.
    @(negedge i_clk);
    i_valid = 1'b1; i_we = 1'b1; i_size = 2'd0; i_addr = 32'h10; i_wdata = 32'h55;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("rmw_read_cmd", 32'(o_ram_do), 32'(`RAM_READ));
    mism = n_wr;
    #1 i_rst = 1'b1;
    #1 check_reset("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_no_write", 32'(n_wr - mism), 32'd0);
    chk("midrst_mem", word_at(32'h10, 1'b0), 32'hDEAD80EF);
    run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 0, got);
    chk("after_rst_store", word_at(32'h10, 1'b0), 32'hDEADBEEF);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) ra = $urandom;
      else if (sel == 1) ra = MEM - 8 + $urandom_range(0, 15);
      else ra = $urandom_range(0, 63);
      run_req(1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 2), got);
    end

    mism = 0;
    for (int i = 0; i < MEM; i++) if (ram[i] != ref_mem[i]) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
